uart_tx_fifo: RTL and testbench

Byte FIFO plus drain controller placed directly upstream of the uart transmitter. Producers push bytes with a single-cycle write strobe at any rate. The block presents one byte at a time to the uart as a one-cycle enable_tx pulse with held tx_data, waits for tx_done, then advances. Message generators no longer need their own per-byte handshake state machine.

---
 rtl/uart_pkg.sv | 16 +
 rtl/byte_fifo.sv | 71 +++++++
 rtl/uart_tx_fifo.sv | 86 ++++++++
 tb/tb_uart_tx_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side FIFO.
//   tx_state_t          drain controller states (IDLE, START, WAIT)
//   UART_TX_FIFO_DEPTH  default number of queued bytes
//   BYTE_W              width of one UART byte
package uart_pkg;

    localparam int unsigned UART_TX_FIFO_DEPTH = 16;
    localparam int unsigned BYTE_W             = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers and a sticky overflow flag.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   push         push strobe; push_data is stored when not full
//   push_data    byte to store
//   pop          pop strobe; advances the read pointer when not empty
//   head_data    byte at the read pointer (combinational)
//   full, empty  occupancy flags (combinational from the pointers)
//   count        occupancy 0..DEPTH (combinational from the pointers)
//   overflow     sticky; set when a push arrives while full
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    // Extra MSB on each pointer distinguishes full from empty when the
    // address bits match.
    assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign count     = wr_ptr - rd_ptr;
    assign head_data = mem[rd_ptr[ADDR_W-1:0]];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            // full is taken from the current pointers, so a push during a
            // pop from a full FIFO is still dropped.
            if (push) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue plus drain controller feeding a UART transmitter.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   wr_en         push strobe, one byte per cycle
//   wr_data       byte to push
//   full, empty   FIFO occupancy flags
//   count         FIFO occupancy 0..DEPTH
//   overflow      sticky, a push was dropped while full
//   enable_tx     one-cycle start pulse to the UART
//   tx_data       byte for the UART, held from start until the next start
//   tx_done       one-cycle pulse from the UART at end of stop bit
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              enable_tx,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done
);

    tx_state_t         state;
    logic [BYTE_W-1:0] head_data;
    logic              pop;

    // The head byte stays in the FIFO while the UART shifts it out; it is
    // only released once the UART reports completion.
    assign pop = (state == WAIT) && tx_done;

    byte_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_data(wr_data),
        .pop      (pop),
        .head_data(head_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            enable_tx <= 1'b0;
            tx_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data   <= head_data;
                        enable_tx <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    enable_tx <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    enable_tx <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a UART model pops expected bytes
// from a scoreboard queue on every enable_tx, plus a table-driven fill
// test and hand-written corner-case sequences.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              enable_tx;
    logic [7:0]        tx_data;
    logic              tx_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sb[$];

    // Main-process controls for the UART model
    logic auto_done;
    int   done_delay;
    logic man_req;

    // UART model state
    logic busy;
    int   en_seen;

    typedef struct {
        logic [7:0] data;
        logic       acc;
        int         exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[17];

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .enable_tx(enable_tx),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART model: acts 1 time unit after each falling edge so it always
    // sees the main process's writes from the same edge.
    initial begin
        logic prev_en;
        logic gap_pending;
        int   gap_edge;
        int   dly;
        tx_done     = 1'b0;
        busy        = 1'b0;
        en_seen     = 0;
        prev_en     = 1'b0;
        gap_pending = 1'b0;
        gap_edge    = 0;
        dly         = 0;
        forever begin
            @(negedge clk);
            #1;
            tx_done = 1'b0;
            if (rst) begin
                busy        = 1'b0;
                prev_en     = 1'b0;
                gap_pending = 1'b0;
            end else begin
                if (enable_tx) begin
                    en_seen++;
                    chk("en_width", int'(prev_en), 0);
                    if (sb.size() == 0) begin
                        chk("start_with_empty_sb", sb.size(), 1);
                    end else begin
                        chk("tx_byte", int'(tx_data), int'(sb.pop_front()));
                    end
                    if (gap_pending) begin
                        chk("idle_gap", cyc, gap_edge);
                        gap_pending = 1'b0;
                    end
                    busy = 1'b1;
                    dly  = done_delay;
                end else if (busy) begin
                    if (!auto_done) begin
                        if (man_req) begin
                            tx_done = 1'b1;
                            busy    = 1'b0;
                        end
                    end else if (dly > 1) begin
                        dly--;
                    end else begin
                        tx_done     = 1'b1;
                        busy        = 1'b0;
                        gap_pending = (count >= 2);
                        gap_edge    = cyc + 2;
                    end
                end
                prev_en = enable_tx;
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic acc);
        wr_en   = 1'b1;
        wr_data = d;
        if (acc) sb.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy), 1);
    endtask

    task automatic manual_done();
        wait_busy("busy_before_done");
        man_req = 1'b1;
        @(negedge clk);
        man_req = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(sb.size() == 0 && empty && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(sb.size() == 0 && empty && !busy), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        int seen;

        for (int i = 0; i < 17; i++) begin
            vecs[i].data      = 8'(i);
            vecs[i].acc       = (i < 16);
            vecs[i].exp_count = (i < 16) ? i + 1 : 16;
            vecs[i].exp_full  = (i >= 15);
            vecs[i].exp_ovf   = (i == 16);
        end

        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        auto_done  = 1'b1;
        done_delay = 50;
        man_req    = 1'b0;

        // Reset state and idle period
        repeat (2) @(negedge clk);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_enable_tx", int'(enable_tx), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_start", en_seen, 0);
        chk("idle_empty", int'(empty), 1);
        chk("idle_tx_data", int'(tx_data), 0);

        // Single byte latency: push at edge k, enable_tx only between k+1 and k+2
        push(8'h48, 1'b1);
        chk("h_en_k", int'(enable_tx), 0);
        chk("h_count_k", int'(count), 1);
        @(negedge clk);
        chk("h_en_k1", int'(enable_tx), 1);
        chk("h_data_k1", int'(tx_data), 8'h48);
        @(negedge clk);
        chk("h_en_k2", int'(enable_tx), 0);
        chk("h_data_k2", int'(tx_data), 8'h48);
        repeat (20) @(negedge clk);
        chk("h_data_wait", int'(tx_data), 8'h48);
        chk("h_count_wait", int'(count), 1);
        wait_drain("h_drain", 100);
        chk("h_count_after", int'(count), 0);
        chk("h_data_after", int'(tx_data), 8'h48);

        // Burst "HI\r\n" on consecutive cycles
        done_delay = 10;
        peak = 0;
        push(8'h48, 1'b1); if (int'(count) > peak) peak = int'(count);
        push(8'h49, 1'b1); if (int'(count) > peak) peak = int'(count);
        push(8'h0D, 1'b1); if (int'(count) > peak) peak = int'(count);
        push(8'h0A, 1'b1); if (int'(count) > peak) peak = int'(count);
        chk("burst_peak_3_or_4", int'(peak >= 3 && peak <= 4), 1);
        wait_drain("burst_drain", 400);

        // Fill past full with the UART stalled
        auto_done = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(vecs[i].data, vecs[i].acc);
            chk($sformatf("fill_count[%0d]", i), int'(count), vecs[i].exp_count);
            chk($sformatf("fill_full[%0d]", i), int'(full), int'(vecs[i].exp_full));
            chk($sformatf("fill_ovf[%0d]", i), int'(overflow), int'(vecs[i].exp_ovf));
        end
        chk("fill_tx_data", int'(tx_data), 8'h00);
        for (int i = 0; i < 16; i++) manual_done();
        wait_drain("fill_drain", 50);
        chk("fill_ovf_sticky", int'(overflow), 1);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_overflow", int'(overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // Push in the same cycle as a pop with count = DEPTH-1
        for (int i = 0; i < 15; i++) push(8'hA0 + 8'(i), 1'b1);
        chk("pp_count_pre", int'(count), 15);
        wait_busy("pp_busy");
        man_req = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hAF;
        sb.push_back(8'hAF);
        @(negedge clk);
        man_req = 1'b0;
        wr_en   = 1'b0;
        chk("pp_count_post", int'(count), 15);
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_full", int'(full), 0);
        for (int i = 0; i < 15; i++) manual_done();
        wait_drain("pp_drain", 50);

        // Reset in the middle of WAIT with bytes queued
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i), 1'b1);
        wait_busy("mr_busy");
        @(negedge clk);
        chk("mr_count_pre", int'(count), 5);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mr_count", int'(count), 0);
        chk("mr_empty", int'(empty), 1);
        chk("mr_enable_tx", int'(enable_tx), 0);
        chk("mr_tx_data", int'(tx_data), 0);
        rst = 1'b0;
        seen = en_seen;
        repeat (5) @(negedge clk);
        chk("mr_no_start", en_seen, seen);
        auto_done  = 1'b1;
        done_delay = 5;
        push(8'h5A, 1'b1);
        wait_drain("mr_drain", 100);
        chk("mr_tx_data_5a", int'(tx_data), 8'h5A);
        chk("mr_count_end", int'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
